// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// FSM state encoding and small decode helpers.
package md_defs;

    // Operation codes carried on mdop. Code 7 is reserved and behaves as NOP.
    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    // FSM states of the unit.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MULT_BUSY = 2'd1,
        DIV_BUSY  = 2'd2
    } md_state_e;

    // True for operations that occupy the unit for MULT_CYCLES.
    function automatic logic is_mult_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    // True for operations that occupy the unit for DIV_CYCLES.
    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// Combinational result generator for the multiply/divide unit.
// Produces the {hi, lo} pair that will be committed when the busy period
// ends, including the divide-by-zero and signed-overflow corner cases.
module md_calc
    import md_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       mdop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   q_s;
    logic [WIDTH-1:0]   r_s;
    logic [WIDTH-1:0]   q_u;
    logic [WIDTH-1:0]   r_u;
    logic               div_zero;
    logic               div_ovf;

    // Sign-extending both operands to 2*WIDTH makes a plain unsigned
    // multiply yield the exact two's-complement signed product.
    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed division is done on magnitudes; the quotient takes the XOR of
    // the operand signs and the remainder follows the dividend.
    assign neg_a = a[WIDTH-1];
    assign neg_b = b[WIDTH-1];
    assign abs_a = neg_a ? (~a + 1'b1) : a;
    assign abs_b = neg_b ? (~b + 1'b1) : b;
    assign q_mag = (abs_b == '0) ? '0 : (abs_a / abs_b);
    assign r_mag = (abs_b == '0) ? '0 : (abs_a % abs_b);
    assign q_s   = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
    assign r_s   = neg_a ? (~r_mag + 1'b1) : r_mag;
    assign q_u   = (b == '0) ? '0 : (a / b);
    assign r_u   = (b == '0) ? '0 : (a % b);

    assign div_zero = (b == '0);
    assign div_ovf  = (a == MOST_NEG) && (b == '1);

    // Select the pending result for the requested operation.
    always_comb begin
        hi = '0;
        lo = '0;
        case (md_op_e'(mdop))
            MD_MULT: begin
                hi = prod_s[2*WIDTH-1:WIDTH];
                lo = prod_s[WIDTH-1:0];
            end
            MD_MULTU: begin
                hi = prod_u[2*WIDTH-1:WIDTH];
                lo = prod_u[WIDTH-1:0];
            end
            MD_DIV: begin
                if (div_zero) begin
                    hi = a;
                    lo = '1;
                end else if (div_ovf) begin
                    hi = '0;
                    lo = MOST_NEG;
                end else begin
                    hi = r_s;
                    lo = q_s;
                end
            end
            MD_DIVU: begin
                if (div_zero) begin
                    hi = a;
                    lo = '1;
                end else begin
                    hi = r_u;
                    lo = q_u;
                end
            end
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
//
// Issue protocol: start is sampled on every rising edge. When the unit is
// idle (busy=0) a start with a MULT/DIV op computes the result into pending
// registers at that edge and busy rises for exactly MULT_CYCLES/DIV_CYCLES
// cycles; HI/LO take the pending result on the edge that ends the last busy
// cycle, so busy falling and the new HI/LO appear together. MTHI/MTLO write
// HI/LO at their issue edge without raising busy. Any start while busy is
// ignored and leaves in-flight state untouched.
module md_unit
    import md_defs::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdop,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [1:0]       dbg_state
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] MULT_LIM = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LIM  = CW'(DIV_CYCLES);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic [WIDTH-1:0] calc_hi;
    logic [WIDTH-1:0] calc_lo;
    md_op_e           op;

    assign op = md_op_e'(mdop);

    md_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .mdop (mdop),
        .a    (rs_data),
        .b    (rt_data),
        .hi   (calc_hi),
        .lo   (calc_lo)
    );

    // Next-state logic: issue decode in IDLE, cycle counting while busy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_mult_op(op)) begin
                        state_d   = MULT_BUSY;
                        cnt_d     = CW'(1);
                        pend_hi_d = calc_hi;
                        pend_lo_d = calc_lo;
                    end else if (is_div_op(op)) begin
                        state_d   = DIV_BUSY;
                        cnt_d     = CW'(1);
                        pend_hi_d = calc_hi;
                        pend_lo_d = calc_lo;
                    end else if (op == MD_MTHI) begin
                        hi_d = rs_data;
                    end else if (op == MD_MTLO) begin
                        lo_d = rs_data;
                    end
                end
            end
            MULT_BUSY: begin
                if (cnt_q == MULT_LIM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DIV_BUSY: begin
                if (cnt_q == DIV_LIM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers with sync reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_md_unit;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   mdop;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         busy;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    // Architectural HI/LO as the model believes them to be.
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mdop      (mdop),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .busy      (busy),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: new HI/LO and busy length for one issued op.
    task automatic model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] nh, output logic [W-1:0] nl, output int cyc);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        sa  = a;
        sb  = b;
        nh  = exp_hi;
        nl  = exp_lo;
        cyc = 0;
        case (op)
            3'd1: begin
                sp = longint'(sa) * longint'(sb);
                nh = sp[63:32]; nl = sp[31:0]; cyc = MC;
            end
            3'd2: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                nh = up[63:32]; nl = up[31:0]; cyc = MC;
            end
            3'd3: begin
                cyc = DC;
                if (b == 0) begin nh = a; nl = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin nh = 0; nl = 32'h8000_0000; end
                else begin nl = sa / sb; nh = sa % sb; end
            end
            3'd4: begin
                cyc = DC;
                if (b == 0) begin nh = a; nl = 32'hFFFF_FFFF; end
                else begin nl = a / b; nh = a % b; end
            end
            3'd5: nh = a;
            3'd6: nl = a;
            default: ;
        endcase
    endtask

    // Issue one op from idle, watch the busy window and check the result.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] nh;
        logic [W-1:0] nl;
        int           cyc;
        int           n;
        model_op(op, a, b, nh, nl, cyc);
        start = 1'b1; mdop = op; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0; mdop = 3'd0;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            checks++;
            if (hi_out !== exp_hi || lo_out !== exp_lo) begin
                errors++;
                $display("FAIL hold_while_busy op=%0d cyc=%0d hi=%h lo=%h expected hi=%h lo=%h",
                         op, n, hi_out, lo_out, exp_hi, exp_lo);
            end
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n !== cyc) begin
            errors++;
            $display("FAIL busy_len op=%0d got %0d expected %0d", op, n, cyc);
        end
        checks++;
        if (hi_out !== nh || lo_out !== nl) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h hi=%h lo=%h expected hi=%h lo=%h",
                     op, a, b, hi_out, lo_out, nh, nl);
        end
        exp_hi = nh;
        exp_lo = nl;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mdop = 3'd0; rs_data = '0; rt_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        checks++;
        if (busy !== 1'b0 || hi_out !== '0 || lo_out !== '0) begin
            errors++;
            $display("FAIL reset_state busy=%b hi=%h lo=%h expected 0 0 0", busy, hi_out, lo_out);
        end
    endtask

    task automatic test_directed();
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        checks++;
        if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFA) begin
            errors++; $display("FAIL mult_neg hi=%h lo=%h expected ffffffff fffffffa", hi_out, lo_out);
        end
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h0000_0001) begin
            errors++; $display("FAIL multu_max hi=%h lo=%h expected fffffffe 00000001", hi_out, lo_out);
        end
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div_neg hi=%h lo=%h expected ffffffff fffffffd", hi_out, lo_out);
        end
        do_op(3'd4, 32'd7, 32'd0);
        checks++;
        if (hi_out !== 32'd7 || lo_out !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL divu_zero hi=%h lo=%h expected 00000007 ffffffff", hi_out, lo_out);
        end
        do_op(3'd3, 32'hFFFF_FFF0, 32'd0);
        checks++;
        if (hi_out !== 32'hFFFF_FFF0 || lo_out !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_zero hi=%h lo=%h expected fffffff0 ffffffff", hi_out, lo_out);
        end
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (hi_out !== 32'h0 || lo_out !== 32'h8000_0000) begin
            errors++; $display("FAIL div_ovf hi=%h lo=%h expected 00000000 80000000", hi_out, lo_out);
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [W-1:0] lo_before;
        lo_before = lo_out;
        start = 1'b1; mdop = 3'd5; rs_data = 32'h1234_5678;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || hi_out !== 32'h1234_5678 || lo_out !== lo_before) begin
            errors++; $display("FAIL mthi busy=%b hi=%h lo=%h expected 0 12345678 %h", busy, hi_out, lo_out, lo_before);
        end
        mdop = 3'd6; rs_data = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0; mdop = 3'd0;
        checks++;
        if (busy !== 1'b0 || hi_out !== 32'h1234_5678 || lo_out !== 32'h9ABC_DEF0) begin
            errors++; $display("FAIL mtlo busy=%b hi=%h lo=%h expected 0 12345678 9abcdef0", busy, hi_out, lo_out);
        end
        exp_hi = 32'h1234_5678; exp_lo = 32'h9ABC_DEF0;
        do_op(3'd0, 32'hFFFF_FFFF, 32'd1);
        do_op(3'd7, 32'hFFFF_FFFF, 32'd1);
    endtask

    task automatic test_ignore_while_busy();
        logic [W-1:0] nh;
        logic [W-1:0] nl;
        int           cyc;
        int           n;
        model_op(3'd3, 32'd100, 32'hFFFF_FFF9, nh, nl, cyc);
        start = 1'b1; mdop = 3'd3; rs_data = 32'd100; rt_data = 32'hFFFF_FFF9;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            if (n == 2) begin start = 1'b1; mdop = 3'd5; rs_data = 32'hDEAD_BEEF; end
            else if (n == 3) begin start = 1'b1; mdop = 3'd1; rs_data = 32'd9; rt_data = 32'd9; end
            else begin start = 1'b0; mdop = 3'd0; end
            n++;
            @(posedge clk); #1;
        end
        start = 1'b0; mdop = 3'd0;
        checks++;
        if (n !== DC) begin
            errors++; $display("FAIL ignore_busy_len got %0d expected %0d", n, DC);
        end
        checks++;
        if (hi_out !== nh || lo_out !== nl) begin
            errors++; $display("FAIL ignore_result hi=%h lo=%h expected hi=%h lo=%h", hi_out, lo_out, nh, nl);
        end
        exp_hi = nh; exp_lo = nl;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL ignore_no_restart busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        start = 1'b1; mdop = 3'd1; rs_data = 32'd12345; rt_data = 32'd678;
        @(posedge clk); #1;
        start = 1'b0; mdop = 3'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi_out !== '0 || lo_out !== '0) begin
            errors++; $display("FAIL reset_mid busy=%b hi=%h lo=%h expected 0 0 0", busy, hi_out, lo_out);
        end
        exp_hi = '0; exp_lo = '0;
        repeat (MC + 1) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || hi_out !== '0 || lo_out !== '0) begin
            errors++; $display("FAIL reset_discard busy=%b hi=%h lo=%h expected 0 0 0", busy, hi_out, lo_out);
        end
    endtask

    // Randomized back-to-back issue with operands biased toward corners.
    task automatic test_back_to_back_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            do_op(op, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_ignore_while_busy();
        test_reset_mid_op();
        test_back_to_back_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
